// File: rtl/mem_dump_reader.sv
// Steps through RAM contents one word at a time for display, taking over the
// RAM read port while dump_mem is high.
//
// state   | meaning
// IDLE    | RAM port released, waiting for dump_mem
// ISSUE   | dump_adr presented to the RAM
// WAIT    | RAM read latency cycle
// CAPTURE | mem_dout registered into dump_data
// SHOW    | dump_data valid, waiting for step / step_back
module mem_dump_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dump_mem,
  input  logic              step,
  input  logic              step_back,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] dump_adr,
  output logic              mem_sel,
  output logic [DATA_W-1:0] dump_data,
  output logic              data_valid,
  output logic              wrapped
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ISSUE   = 3'd1;
  localparam logic [2:0] WAIT    = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] SHOW    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wrapped_q, wrapped_d;

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    data_d    = data_q;
    wrapped_d = wrapped_q;
    case (state_q)
      IDLE: begin
        if (dump_mem) begin
          adr_d     = '0;
          wrapped_d = 1'b0;
          state_d   = ISSUE;
        end
      end
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        data_d  = mem_dout;
        state_d = SHOW;
      end
      SHOW: begin
        if (step && !step_back) begin
          adr_d = adr_q + 1'b1;
          if (adr_q == '1) wrapped_d = 1'b1;
          state_d = ISSUE;
        end else if (step_back && !step) begin
          adr_d = adr_q - 1'b1;
          if (adr_q == '0) wrapped_d = 1'b1;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Leaving dump mode freezes address and data, discarding any step or capture.
    if (state_q != IDLE && !dump_mem) begin
      state_d   = IDLE;
      adr_d     = adr_q;
      data_d    = data_q;
      wrapped_d = wrapped_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      adr_q     <= '0;
      data_q    <= '0;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign dump_adr   = adr_q;
  assign dump_data  = data_q;
  assign wrapped    = wrapped_q;
  assign mem_sel    = (state_q != IDLE);
  assign data_valid = (state_q == SHOW);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Bench for mem_dump_reader: RAM holding A500+a, a cycle-count model of the
// dump sequence, directed scenarios then randomized stimulus.
module tb_mem_dump_reader;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dump_mem = 1'b0;
  logic        step = 1'b0;
  logic        step_back = 1'b0;
  logic [15:0] mem_dout;
  logic [7:0]  dump_adr;
  logic        mem_sel;
  logic [15:0] dump_data;
  logic        data_valid;
  logic        wrapped;

  int n_cmp = 0;
  int n_bad = 0;

  mem_dump_reader #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .dump_mem(dump_mem), .step(step),
    .step_back(step_back), .mem_dout(mem_dout), .dump_adr(dump_adr),
    .mem_sel(mem_sel), .dump_data(dump_data), .data_valid(data_valid),
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  logic [15:0] ram [256];
  initial for (int a = 0; a < 256; a++) ram[a] = 16'hA500 + 16'(a);
  always @(posedge clk) mem_dout <= ram[dump_adr];

  function automatic logic [15:0] word(input int a);
    return 16'hA500 + 16'(a);
  endfunction

  // Model: active = dump mode, pend = cycles left until the word is shown.
  bit          m_started = 0;
  bit          m_act = 0;
  int          m_pend = 0;
  int          m_adr = 0;
  logic [15:0] m_data = 16'h0;
  bit          m_wrap = 0;

  always @(posedge clk) begin
    m_started = 1;
    if (reset) begin
      m_act = 0; m_pend = 0; m_adr = 0; m_data = 16'h0; m_wrap = 0;
    end else if (!m_act) begin
      if (dump_mem) begin
        m_act = 1; m_pend = 3; m_adr = 0; m_wrap = 0;
      end
    end else if (!dump_mem) begin
      m_act = 0;
    end else if (m_pend > 0) begin
      if (m_pend == 1) m_data = word(m_adr);
      m_pend = m_pend - 1;
    end else if (step != step_back) begin
      if (step) begin
        if (m_adr == 255) m_wrap = 1;
        m_adr = (m_adr + 1) % 256;
      end else begin
        if (m_adr == 0) m_wrap = 1;
        m_adr = (m_adr + 255) % 256;
      end
      m_pend = 3;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_started) begin
      check("mem_sel", 32'(mem_sel), 32'(m_act));
      check("data_valid", 32'(data_valid), 32'(m_act && m_pend == 0));
      check("dump_adr", 32'(dump_adr), 32'(m_adr));
      check("dump_data", 32'(dump_data), 32'(m_data));
      check("wrapped", 32'(wrapped), 32'(m_wrap));
    end
  end

  task automatic tick(input logic r, input logic d, input logic s, input logic b);
    @(negedge clk);
    reset = r; dump_mem = d; step = s; step_back = b;
  endtask

  task automatic after();
    @(posedge clk);
    #1;
  endtask

  task automatic step_once(input logic s, input logic b);
    tick(0, 1, s, b);
    after();
    check("lit_step_dv_low", 32'(data_valid), 32'd0);
    repeat (3) tick(0, 1, 0, 0);
    after();
    check("lit_step_dv_high", 32'(data_valid), 32'd1);
  endtask

  initial begin
    tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    after();
    check("lit_rst_mem_sel", 32'(mem_sel), 32'd0);
    check("lit_rst_adr", 32'(dump_adr), 32'd0);
    check("lit_rst_data", 32'(dump_data), 32'd0);

    tick(0, 1, 0, 0);
    after();
    check("lit_entry_mem_sel", 32'(mem_sel), 32'd1);
    check("lit_entry_dv", 32'(data_valid), 32'd0);
    repeat (3) tick(0, 1, 0, 0);
    after();
    check("lit_first_dv", 32'(data_valid), 32'd1);
    check("lit_first_data", 32'(dump_data), 32'hA500);

    repeat (3) step_once(1, 0);
    check("lit_step3_adr", 32'(dump_adr), 32'd3);
    check("lit_step3_data", 32'(dump_data), 32'hA503);

    repeat (4) step_once(0, 1);
    check("lit_back_adr", 32'(dump_adr), 32'hFF);
    check("lit_back_data", 32'(dump_data), 32'hA5FF);
    check("lit_back_wrap", 32'(wrapped), 32'd1);
    step_once(1, 0);
    check("lit_fwd_adr", 32'(dump_adr), 32'd0);
    check("lit_fwd_wrap", 32'(wrapped), 32'd1);

    tick(0, 1, 1, 1);
    after();
    check("lit_both_dv", 32'(data_valid), 32'd1);
    check("lit_both_adr", 32'(dump_adr), 32'd0);

    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    after();
    check("lit_waitstep_adr", 32'(dump_adr), 32'd1);
    check("lit_waitstep_data", 32'(dump_data), 32'hA501);

    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 1, 0);
    after();
    check("lit_drop_mem_sel", 32'(mem_sel), 32'd0);
    check("lit_drop_dv", 32'(data_valid), 32'd0);
    check("lit_drop_adr", 32'(dump_adr), 32'd2);
    check("lit_drop_data", 32'(dump_data), 32'hA501);
    tick(0, 1, 0, 0);
    after();
    check("lit_reraise_adr", 32'(dump_adr), 32'd0);
    check("lit_reraise_wrap", 32'(wrapped), 32'd0);
    repeat (3) tick(0, 1, 0, 0);

    repeat (4) step_once(1, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    after();
    check("lit_capt_adr", 32'(dump_adr), 32'd5);
    tick(1, 1, 0, 0);
    after();
    check("lit_rst5_adr", 32'(dump_adr), 32'd0);
    check("lit_rst5_data", 32'(dump_data), 32'd0);
    check("lit_rst5_mem_sel", 32'(mem_sel), 32'd0);
    check("lit_rst5_dv", 32'(data_valid), 32'd0);
    repeat (3) tick(0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      tick(($urandom_range(0, 127) == 0),
           ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0));
    end
    tick(0, 0, 0, 0);
    after();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameters: ADDR_W, default 8, RAM address width; DATA_W, default 16, RAM data width.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 dump_mem  input  1  level; 1 = dump mode owns the RAM read port.
REQ-005 step  input  1  single-cycle pulse from one_shot; advance the address by one.
REQ-006 step_back  input  1  single-cycle pulse from one_shot; move the address back by one.
REQ-007 mem_dout  input  DATA_W  RAM read data; synchronous read, valid in the cycle after the address is sampled.
REQ-008 dump_adr  output  ADDR_W  dump address counter, driven to the RAM address mux.
REQ-009 mem_sel  output  1  1 = RAM address mux selects dump_adr and RAM writes are blocked.
REQ-010 dump_data  output  DATA_W  registered word at dump_adr, for display.
REQ-011 data_valid  output  1  1 = dump_data matches the current dump_adr.
REQ-012 wrapped  output  1  sticky flag; the counter has wrapped in either direction since dump entry.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT, CAPTURE and SHOW, and SHALL stay exactly one cycle in each of ISSUE, WAIT and CAPTURE.
REQ-014 IDLE with dump_mem=1 SHALL load the counter with 0, clear wrapped, and go to ISSUE.
REQ-015 ISSUE SHALL present dump_adr to the RAM and then go to WAIT.
REQ-016 WAIT SHALL allow mem_dout to settle and then go to CAPTURE.
REQ-017 CAPTURE SHALL register mem_dout into dump_data and then go to SHOW.
REQ-018 SHOW SHALL hold dump_data until a valid step or step_back is sampled.
REQ-019 In SHOW, step=1 with step_back=0 SHALL increment the counter and go to ISSUE.
REQ-020 In SHOW, step_back=1 with step=0 SHALL decrement the counter and go to ISSUE.
REQ-021 In SHOW, step and step_back both 1 SHALL leave the counter and state unchanged.
REQ-022 Step pulses outside SHOW SHALL be ignored and SHALL NOT be queued.
REQ-023 The counter SHALL wrap from all-ones to 0 on increment and from 0 to all-ones on decrement, and each wrap SHALL set wrapped.
REQ-024 data_valid SHALL be 1 only in SHOW.
REQ-025 After a step accepted in cycle k, data_valid SHALL be 0 in cycles k+1..k+3 and 1 in cycle k+4 with the new word.
REQ-026 mem_sel SHALL be 1 in every state except IDLE.
REQ-027 dump_mem=0 sampled in any non-IDLE state SHALL force IDLE at the next edge, so mem_sel and data_valid are 0 the following cycle.
REQ-028 On forced IDLE, dump_adr and dump_data SHALL retain their values.
REQ-029 Any step sampled in the same cycle that forces IDLE SHALL be ignored.
REQ-030 Re-asserting dump_mem SHALL always restart at address 0.
REQ-031 All outputs SHALL be registered or decoded from the state register only, with no combinational path from any input to any output.

Reset
REQ-032 reset=1 SHALL override all other inputs, including mid-read and in SHOW.
REQ-033 At reset the block SHALL set: state IDLE, dump_adr 0, dump_data 0, data_valid 0, mem_sel 0, wrapped 0.
REQ-034 A reset held together with dump_mem=1 SHALL remain in IDLE.
REQ-035 After reset releases with dump_mem=1, the block SHALL enter ISSUE on the next edge.

Verification
REQ-036 RAM preloaded with word(a)=16'hA500+a; raise dump_mem in cycle j -> mem_sel=1 at j+1, data_valid=1 at j+4, dump_adr=0, dump_data=16'hA500.
REQ-037 Three step pulses, each accepted in SHOW -> dump_adr=3, dump_data=16'hA503; each pulse gives data_valid low 3 cycles, then high.
REQ-038 step_back at address 0 -> dump_adr=8'hFF, dump_data=16'hA5FF, wrapped=1; a following step -> dump_adr=0, wrapped stays 1.
REQ-039 step and step_back in the same SHOW cycle -> dump_adr unchanged, data_valid stays 1; a step pulse during WAIT -> ignored, dump_adr unchanged.
REQ-040 dump_mem dropped during WAIT -> IDLE next edge, mem_sel=0, data_valid=0, dump_adr held; re-raise -> dump_adr=0, wrapped=0.
REQ-041 reset pulse in CAPTURE at address 5 -> all outputs reach reset values the next cycle; the 16'hA505 data is never presented.
